drag_tree_ctrl: RTL and testbench

//  Multi-lane drag-race start tree. Supersedes the single-lane light FSM with a

---
 rtl/drag_tree_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_drag_tree_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/drag_tree_ctrl.sv
// drag_tree_ctrl: multi-lane drag-race start tree.
// One shared sequencer (IDLE -> STAGED -> AMBER -> GREEN -> DONE) drives every
// lane. Red (foul) and finish tracking are kept per lane. Lamp outputs and
// running are registered, so they follow the sequencer state by one clock.
// PSL/SL mirror the beams combinationally.
// Build option: define REACTION_TIMER_EN to add per-lane reaction-time
// counters on rt. Without it, rt is tied to 0 and the port list is unchanged.
module drag_tree_ctrl #(
    parameter int LANES          = 2,
    parameter int AMBERS         = 3,
    parameter int TICKS_PER_STEP = 25_000_000,
    parameter int CNT_W          = 25,
    parameter int RT_W           = 24
) (
    input  logic                    CLOCK_50,
    input  logic                    Reset,
    input  logic                    pro_mode,
    input  logic [LANES-1:0]        PSB,
    input  logic [LANES-1:0]        SB,
    output logic [LANES-1:0]        PSL,
    output logic [LANES-1:0]        SL,
    output logic [LANES*AMBERS-1:0] AMB,
    output logic [LANES-1:0]        G,
    output logic [LANES-1:0]        R,
    output logic                    running,
    output logic [LANES*RT_W-1:0]   rt
);
    localparam int               IDX_W    = (AMBERS > 1) ? $clog2(AMBERS) : 1;
    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TICKS_PER_STEP - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(AMBERS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        STAGED = 3'd1,
        AMBER  = 3'd2,
        GREEN  = 3'd3,
        DONE   = 3'd4
    } state_t;

    genvar gi;
    genvar gj;

    // Sequencer state
    state_t                  state_reg;
    logic [CNT_W-1:0]        cnt_reg;
    logic [IDX_W-1:0]        idx_reg;
    logic                    mode_reg;
    logic [LANES-1:0]        fin_reg;

    // Registered lamp drivers
    logic [LANES-1:0]        r_reg;
    logic [LANES-1:0]        g_reg;
    logic [LANES*AMBERS-1:0] amb_reg;
    logic                    running_reg;

    // Combinational helpers
    logic                    all_staged;
    logic                    step_end;
    logic                    last_step;
    logic [LANES-1:0]        fouled_next;
    logic [LANES-1:0]        fin_next;
    logic [LANES-1:0]        g_next;
    logic                    running_next;
    logic [LANES*AMBERS-1:0] amb_next;

    assign PSL     = PSB;
    assign SL      = SB;
    assign AMB     = amb_reg;
    assign G       = g_reg;
    assign R       = r_reg;
    assign running = running_reg;

    // Shared step timing plus per-lane foul and finish conditions for this cycle.
    always_comb begin
        all_staged   = &SB;
        step_end     = (cnt_reg == TERM_CNT);
        // Pro tree has a single amber step; sportsman walks every amber.
        last_step    = mode_reg || (idx_reg == LAST_IDX);
        // Any beam drop while ambers are showing is a foul, terminal cycle included.
        fouled_next  = (state_reg == AMBER) ? (r_reg | ~SB) : r_reg;
        // In GREEN a lane is finished once its beam drops; fouled lanes count as finished.
        fin_next     = fin_reg | ~SB | r_reg;
        g_next       = ((state_reg == GREEN) || (state_reg == DONE)) ? ~fouled_next : '0;
        running_next = (state_reg == STAGED) || (state_reg == AMBER) || (state_reg == GREEN);
    end

    // Amber pattern: one lamp per step (sportsman) or all lamps (pro), dark on fouled lanes.
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            for (gj = 0; gj < AMBERS; gj++) begin : g_amber
                assign amb_next[gi*AMBERS+gj] = (state_reg == AMBER) && !fouled_next[gi]
                                             && (mode_reg || (idx_reg == IDX_W'(gj)));
            end
        end
    endgenerate

    // Tree sequencer with registered lamp drivers; Reset low clears everything.
    always_ff @(posedge CLOCK_50) begin
        if (!Reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            idx_reg     <= '0;
            mode_reg    <= 1'b0;
            fin_reg     <= '0;
            r_reg       <= '0;
            g_reg       <= '0;
            amb_reg     <= '0;
            running_reg <= 1'b0;
        end else begin
            g_reg       <= g_next;
            amb_reg     <= amb_next;
            running_reg <= running_next;
            r_reg       <= fouled_next;
            case (state_reg)
                IDLE: begin
                    if (all_staged) begin
                        mode_reg  <= pro_mode;
                        cnt_reg   <= '0;
                        state_reg <= STAGED;
                    end
                end
                STAGED: begin
                    if (!all_staged) begin
                        state_reg <= IDLE;
                    end else if (step_end) begin
                        state_reg <= AMBER;
                        idx_reg   <= '0;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                AMBER: begin
                    if (&fouled_next) begin
                        state_reg <= DONE;
                    end else if (step_end) begin
                        cnt_reg <= '0;
                        if (last_step) begin
                            state_reg <= GREEN;
                            fin_reg   <= fouled_next;
                        end else begin
                            idx_reg <= idx_reg + IDX_W'(1);
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                GREEN: begin
                    fin_reg <= fin_next;
                    if (&fin_next) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    // Held until Reset.
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef REACTION_TIMER_EN
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_rt
            logic [RT_W-1:0] rt_reg;

            // Reaction time: counts GREEN clocks until the beam drops, saturating; fouls read all-ones.
            always_ff @(posedge CLOCK_50) begin
                if (!Reset) begin
                    rt_reg <= '0;
                end else if (fouled_next[gi]) begin
                    rt_reg <= '1;
                end else if (state_reg == GREEN) begin
                    if (!fin_reg[gi] && SB[gi] && (rt_reg != '1)) begin
                        rt_reg <= rt_reg + RT_W'(1);
                    end
                end else if (state_reg != DONE) begin
                    rt_reg <= '0;
                end
            end

            assign rt[gi*RT_W +: RT_W] = rt_reg;
        end
    endgenerate
`else
    assign rt = '0;
`endif

endmodule

// File: tb/tb_drag_tree_ctrl.sv
// Testbench for drag_tree_ctrl (LANES=2, AMBERS=3, TICKS_PER_STEP=4, RT_W=4).
// A timeline reference model derives the expected lamps from the number of
// clocks elapsed since staging. Directed scenarios are followed by random races.
module tb_drag_tree_ctrl;
    localparam int LANES  = 2;
    localparam int AMBERS = 3;
    localparam int TPS    = 4;
    localparam int CNT_W  = 2;
    localparam int RT_W   = 4;
    localparam int RT_SAT = 15;
`ifdef REACTION_TIMER_EN
    localparam bit RT_ON = 1'b1;
`else
    localparam bit RT_ON = 1'b0;
`endif

    logic                    CLOCK_50;
    logic                    Reset;
    logic                    pro_mode;
    logic [LANES-1:0]        PSB;
    logic [LANES-1:0]        SB;
    logic [LANES-1:0]        PSL;
    logic [LANES-1:0]        SL;
    logic [LANES*AMBERS-1:0] AMB;
    logic [LANES-1:0]        G;
    logic [LANES-1:0]        R;
    logic                    running;
    logic [LANES*RT_W-1:0]   rt;

    drag_tree_ctrl #(
        .LANES(LANES), .AMBERS(AMBERS), .TICKS_PER_STEP(TPS), .CNT_W(CNT_W), .RT_W(RT_W)
    ) dut (
        .CLOCK_50(CLOCK_50), .Reset(Reset), .pro_mode(pro_mode),
        .PSB(PSB), .SB(SB), .PSL(PSL), .SL(SL),
        .AMB(AMB), .G(G), .R(R), .running(running), .rt(rt)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    int checks;
    int errors;

    // Reference model: timeline since staging edge
    int                      cyc;
    int                      t0;
    bit                      act;
    bit                      done_m;
    bit                      m_pro;
    logic [LANES-1:0]        foul;
    logic [LANES-1:0]        fin;
    int                      rtc [LANES];
    logic [LANES*AMBERS-1:0] e_amb;
    logic [LANES-1:0]        e_g;
    logic [LANES-1:0]        e_r;
    logic                    e_run;
    logic [LANES*RT_W-1:0]   e_rt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected outputs after one clock edge, from the elapsed time since staging.
    task automatic model_edge(input logic [LANES-1:0] sb, input logic rst_n, input logic pro);
        int e;
        int nsteps;
        int k;
        cyc++;
        e_amb = '0;
        e_g   = '0;
        e_run = 1'b0;
        if (!rst_n) begin
            act    = 1'b0;
            done_m = 1'b0;
            foul   = '0;
            fin    = '0;
            for (int l = 0; l < LANES; l++) rtc[l] = 0;
        end else if (done_m) begin
            e_g = ~foul;
        end else if (!act) begin
            if (&sb) begin
                act   = 1'b1;
                t0    = cyc;
                m_pro = pro;
                fin   = '0;
                for (int l = 0; l < LANES; l++) rtc[l] = 0;
            end
        end else begin
            e      = cyc - t0;
            nsteps = m_pro ? 1 : AMBERS;
            e_run  = 1'b1;
            if (e <= TPS) begin
                if (!(&sb)) act = 1'b0;
            end else if (e <= TPS + nsteps * TPS) begin
                k    = (e - TPS - 1) / TPS;
                foul = foul | ~sb;
                for (int l = 0; l < LANES; l++)
                    for (int j = 0; j < AMBERS; j++)
                        if (!foul[l] && (m_pro || j == k)) e_amb[l*AMBERS+j] = 1'b1;
                if (&foul) done_m = 1'b1;
            end else begin
                for (int l = 0; l < LANES; l++)
                    if (!fin[l] && !foul[l] && sb[l] && rtc[l] < RT_SAT) rtc[l]++;
                fin = fin | ~sb | foul;
                e_g = ~foul;
                if (&fin) done_m = 1'b1;
            end
        end
        e_r = foul;
        for (int l = 0; l < LANES; l++)
            e_rt[l*RT_W +: RT_W] = !RT_ON ? '0 : (foul[l] ? RT_W'(RT_SAT) : RT_W'(rtc[l]));
    endtask

    // One clock: drive inputs, advance the model, check every output.
    task automatic tick(input logic [LANES-1:0] sb, input logic rst_n, input logic pro);
        SB       = sb;
        Reset    = rst_n;
        pro_mode = pro;
        PSB      = 2'($urandom_range(0, 3));
        @(posedge CLOCK_50);
        model_edge(sb, rst_n, pro);
        #1;
        check("AMB", 64'(AMB), 64'(e_amb));
        check("G", 64'(G), 64'(e_g));
        check("R", 64'(R), 64'(e_r));
        check("running", 64'(running), 64'(e_run));
        check("rt", 64'(rt), 64'(e_rt));
        check("PSL", 64'(PSL), 64'(PSB));
        check("SL", 64'(SL), 64'(SB));
    endtask

    initial begin
        logic [LANES*RT_W-1:0] exp_rt6;
        int up [LANES];
        int dn [LANES];
        logic [LANES-1:0] sbr;

        checks = 0; errors = 0; cyc = 0; t0 = 0;
        act = 1'b0; done_m = 1'b0; m_pro = 1'b0; foul = '0; fin = '0;
        for (int l = 0; l < LANES; l++) rtc[l] = 0;
        SB = '0; PSB = '0; Reset = 1'b0; pro_mode = 1'b0;

        // Reset state
        tick(2'b00, 1'b0, 1'b0);
        tick(2'b00, 1'b0, 1'b0);
        check("rst_amb", 64'(AMB), 64'd0);
        check("rst_g", 64'(G), 64'd0);
        check("rst_run", 64'(running), 64'd0);

        // 1. Sportsman tree, both lanes staged throughout
        tick(2'b11, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin tick(2'b11, 1'b1, 1'b0); check("s1_staged", 64'(AMB), 64'd0); end
        for (int i = 0; i < 4; i++) begin tick(2'b11, 1'b1, 1'b0); check("s1_amber0", 64'(AMB), 64'b001001); end
        for (int i = 0; i < 4; i++) begin tick(2'b11, 1'b1, 1'b0); check("s1_amber1", 64'(AMB), 64'b010010); end
        for (int i = 0; i < 4; i++) begin tick(2'b11, 1'b1, 1'b0); check("s1_amber2", 64'(AMB), 64'b100100); end
        tick(2'b11, 1'b1, 1'b0);
        check("s1_green", 64'(G), 64'b11);
        check("s1_red", 64'(R), 64'd0);
        tick(2'b00, 1'b1, 1'b0);
        tick(2'b00, 1'b1, 1'b0);
        check("s1_done_g", 64'(G), 64'b11);
        check("s1_done_run", 64'(running), 64'd0);

        // 2. Pro tree, pro_mode toggling after staging
        tick(2'b11, 1'b0, 1'b0);
        tick(2'b11, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) tick(2'b11, 1'b1, 1'(i & 1));
        for (int i = 0; i < 4; i++) begin tick(2'b11, 1'b1, 1'(i & 1)); check("s2_all_amb", 64'(AMB), 64'b111111); end
        tick(2'b11, 1'b1, 1'b0);
        check("s2_green", 64'(G), 64'b11);

        // 3. Lane 1 fouls in the second amber step
        tick(2'b00, 1'b0, 1'b0);
        tick(2'b11, 1'b1, 1'b0);
        for (int i = 1; i < 10; i++) tick(2'b11, 1'b1, 1'b0);
        tick(2'b01, 1'b1, 1'b0);
        check("s3_red", 64'(R), 64'b10);
        check("s3_amb", 64'(AMB), 64'b000010);
        for (int i = 11; i < 18; i++) tick(2'b01, 1'b1, 1'b0);
        check("s3_green", 64'(G), 64'b01);
        tick(2'b00, 1'b1, 1'b0);
        tick(2'b00, 1'b1, 1'b0);
        check("s3_done_run", 64'(running), 64'd0);

        // 4. Drop during STAGED, then restage and foul both lanes
        tick(2'b00, 1'b0, 1'b0);
        tick(2'b11, 1'b1, 1'b0);
        tick(2'b11, 1'b1, 1'b0);
        tick(2'b01, 1'b1, 1'b0);
        check("s4_no_red", 64'(R), 64'd0);
        tick(2'b01, 1'b1, 1'b0);
        check("s4_idle_run", 64'(running), 64'd0);
        tick(2'b11, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) tick(2'b11, 1'b1, 1'b0);
        tick(2'b00, 1'b1, 1'b0);
        check("s4_red_both", 64'(R), 64'b11);
        tick(2'b00, 1'b1, 1'b0);
        check("s4_done_g", 64'(G), 64'd0);
        check("s4_done_run", 64'(running), 64'd0);

        // 5. Reset pulse mid-AMBER, then restart from step 0
        tick(2'b00, 1'b0, 1'b0);
        tick(2'b11, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) tick(2'b11, 1'b1, 1'b0);
        tick(2'b11, 1'b0, 1'b0);
        check("s5_rst_amb", 64'(AMB), 64'd0);
        check("s5_rst_run", 64'(running), 64'd0);
        tick(2'b11, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) tick(2'b11, 1'b1, 1'b0);
        tick(2'b11, 1'b1, 1'b0);
        check("s5_restart_amb", 64'(AMB), 64'b001001);

        // 6. Reaction time: lane 0 launches 7 clocks into GREEN, lane 1 fouled
        tick(2'b00, 1'b0, 1'b0);
        tick(2'b11, 1'b1, 1'b0);
        for (int i = 1; i < 6; i++) tick(2'b11, 1'b1, 1'b0);
        for (int i = 6; i < 24; i++) tick(2'b01, 1'b1, 1'b0);
        tick(2'b00, 1'b1, 1'b0);
        exp_rt6 = RT_ON ? 8'hF7 : 8'h00;
        check("s6_rt", 64'(rt), 64'(exp_rt6));
        check("s6_g", 64'(G), 64'b01);

        // Random races with toggling pro_mode and occasional reset pulses
        for (int race = 0; race < 60; race++) begin
            tick(2'b00, 1'b0, 1'($urandom_range(0, 1)));
            for (int l = 0; l < LANES; l++) begin
                up[l] = $urandom_range(0, 4);
                dn[l] = up[l] + $urandom_range(1, 40);
            end
            for (int t = 0; t < 48; t++) begin
                for (int l = 0; l < LANES; l++) sbr[l] = (t >= up[l]) && (t < dn[l]);
                tick(sbr, ($urandom_range(0, 99) != 0), 1'($urandom_range(0, 1)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
